// File: rtl/ins_mem_loader_if.sv
// Host byte stream and processor fetch port of the instruction memory loader.
interface ins_mem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [8:0]  insMemAddr;
  logic [31:0] insMemDataIn;
  logic        insMemEn;
  logic        load_done;
  logic        load_error;
  logic [9:0]  words_loaded;

  modport master (
    output rx_valid, rx_data, insMemAddr,
    input  insMemDataIn, insMemEn, load_done, load_error, words_loaded
  );

  modport slave (
    input  rx_valid, rx_data, insMemAddr,
    output insMemDataIn, insMemEn, load_done, load_error, words_loaded
  );
endinterface

// File: rtl/ins_mem_loader.sv
// 512x32 instruction store with a framed host byte-stream loader; holds the
// processor on NOPs (insMemEn) while a program is being loaded.
module ins_mem_loader #(
  parameter int unsigned DEPTH          = 512,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic             clock,
  input  logic             reset,
  ins_mem_loader_if.slave  bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t      state;
  logic [31:0] mem [DEPTH];
  logic        en_q, done_q, err_q;
  logic [9:0]  words_q;
  logic [9:0]  n_q;
  logic [7:0]  len_lo_q;
  logic [8:0]  addr_q;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic [7:0]  chk_q;
  logic [TW-1:0] tmo_q;
  logic [9:0]  n_next;
  logic        we;

  assign n_next = {bus.rx_data[1:0], len_lo_q};

  // Write on the edge that accepts the 4th byte; reset suppresses a pending write.
  assign we = (state == S_DATA) && bus.rx_valid && (byte_idx == 2'd3) && !reset;

  always_ff @(posedge clock) begin
    if (we) mem[addr_q] <= {bus.rx_data, word_buf};
  end

  assign bus.insMemDataIn = mem[bus.insMemAddr];
  assign bus.insMemEn     = en_q;
  assign bus.load_done    = done_q;
  assign bus.load_error   = err_q;
  assign bus.words_loaded = words_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      en_q     <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      words_q  <= '0;
      n_q      <= '0;
      len_lo_q <= '0;
      addr_q   <= '0;
      byte_idx <= '0;
      word_buf <= '0;
      chk_q    <= '0;
      tmo_q    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          tmo_q <= '0;
          if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
            state   <= S_LEN_LO;
            en_q    <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            words_q <= '0;
            chk_q   <= '0;
          end
        end
        default: begin
          // In-frame: idle cycles count toward abort, any byte restarts the count.
          if (!bus.rx_valid) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
              state <= S_ERROR;
              err_q <= 1'b1;
              tmo_q <= '0;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end else begin
            tmo_q <= '0;
            case (state)
              S_LEN_LO: begin
                len_lo_q <= bus.rx_data;
                state    <= S_LEN_HI;
              end
              S_LEN_HI: begin
                n_q <= n_next;
                if (n_next == '0 || n_next > 10'(DEPTH)) begin
                  state <= S_ERROR;
                  err_q <= 1'b1;
                end else begin
                  state    <= S_DATA;
                  addr_q   <= '0;
                  byte_idx <= '0;
                end
              end
              S_DATA: begin
                chk_q    <= chk_q ^ bus.rx_data;
                byte_idx <= byte_idx + 1'b1;
                if (byte_idx != 2'd3) begin
                  word_buf[8*byte_idx +: 8] <= bus.rx_data;
                end else begin
                  words_q <= words_q + 1'b1;
                  if (words_q + 1'b1 == n_q) state <= S_CHECK;
                  else                       addr_q <= addr_q + 1'b1;
                end
              end
              S_CHECK: begin
                if (bus.rx_data == chk_q) begin
                  state  <= S_DONE;
                  done_q <= 1'b1;
                  en_q   <= 1'b0;
                end else begin
                  state <= S_ERROR;
                  err_q <= 1'b1;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule
